// File: rtl/sum_accumulator_8bits.sv
// -----------------------------------------------------------------------------
// sum_accumulator_8bits
//
// Reduction stage behind the 8-bit ripple-carry adder. It sums N_SAMPLES
// consecutive 9-bit beats {Cout,S} into an ACC_W-bit total. The total is
// presented on a registered valid/ready output port.
//
// Parameters
//   N_SAMPLES  beats per result (>= 1)
//   ACC_W      accumulator / result width (>= 9)
//
// Optional feature
//   ACC_SAT_EN  When defined, an addition that carries out of ACC_W bits
//               saturates the accumulator to all-ones. When undefined, the
//               accumulator wraps modulo 2^ACC_W. In both cases the overflow
//               flag is set.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset. Deassertion is expected to be
//              synchronised to clk upstream.
//   in_valid   {Cout,S} beat is valid
//   in_ready   block can accept a beat (combinational)
//   S          sum bits from the adder
//   Cout       carry-out from the adder
//   clear      synchronous abort: drops any partial or pending result
//   out_valid  acc_out / overflow hold a completed result
//   out_ready  downstream accepts the result
//   acc_out    accumulated total (registered)
//   overflow   at least one addition of this result carried out of ACC_W bits
// -----------------------------------------------------------------------------
module sum_accumulator_8bits #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       S,
  input  logic             Cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] acc_q;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic             carry;
  logic             accept;
  logic             last_beat;

  // acc_q is zero whenever the FSM sits in IDLE or DONE. The first beat of a
  // result therefore loads the operand through the same adder as later beats.
  assign operand   = ACC_W'({Cout, S});
  assign sum_wide  = {1'b0, acc_q} + {1'b0, operand};
  assign carry     = sum_wide[ACC_W];
  assign in_ready  = (state_q != DONE) && !clear;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count_q == LAST_CNT);

`ifdef ACC_SAT_EN
  // Once saturated, acc_q is all-ones. Any further non-zero operand carries
  // again, so the accumulator stays pinned at all-ones.
  assign sum_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign sum_next = sum_wide[ACC_W-1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch forms.
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            state_d = last_beat ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: accumulator, beat counter, result register and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      count_q  <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc_q    <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (carry) begin
        overflow <= 1'b1;
      end
      if (last_beat) begin
        acc_out <= sum_next;
        acc_q   <= '0;
        count_q <= '0;
      end else begin
        acc_q   <= sum_next;
        count_q <= count_q + CNT_W'(1);
      end
    end else if (out_valid && out_ready) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accumulator_8bits.sv
// -----------------------------------------------------------------------------
// Bench for sum_accumulator_8bits. Three instances share one stimulus stream:
//   u_main : N_SAMPLES=8, ACC_W=16
//   u_w9   : N_SAMPLES=2, ACC_W=9
//   u_n1   : N_SAMPLES=1, ACC_W=16
// Each instance has a reference model. The model keeps a running integer sum
// and a beat count. Wrap and saturation are applied with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_sum_accumulator_8bits;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [7:0] s;
  logic cout;
  logic clear;
  logic out_ready;

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  overflow_w;
  logic [15:0] acc0;
  logic [8:0]  acc1;
  logic [15:0] acc2;

  always #5 clk = ~clk;

  sum_accumulator_8bits #(.N_SAMPLES(8), .ACC_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .S(s), .Cout(cout), .clear(clear), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .acc_out(acc0), .overflow(overflow_w[0]));

  sum_accumulator_8bits #(.N_SAMPLES(2), .ACC_W(9)) u_w9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .S(s), .Cout(cout), .clear(clear), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .acc_out(acc1), .overflow(overflow_w[1]));

  sum_accumulator_8bits #(.N_SAMPLES(1), .ACC_W(16)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .S(s), .Cout(cout), .clear(clear), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .acc_out(acc2), .overflow(overflow_w[2]));

`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model configuration and state, one entry per instance
  int     n_cfg [3] = '{8, 2, 1};
  int     w_cfg [3] = '{16, 9, 16};
  int     m_cnt [3];
  longint m_sum [3];
  bit     m_ovf [3];
  bit     m_pend[3];
  longint m_res [3];
  bit     m_rovf[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] acc_obs(input int i);
    case (i)
      0:       return {16'b0, acc0};
      1:       return {23'b0, acc1};
      default: return {16'b0, acc2};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_sum[i] = 0; m_ovf[i] = 0;
      m_pend[i] = 0; m_res[i] = 0; m_rovf[i] = 0;
    end
  endtask

  // Advance one instance's model across the coming rising edge
  task automatic model_step(input int i, input bit iv, input longint op,
                            input bit cl, input bit ordy);
    longint maxv;
    longint t;
    maxv = (longint'(1) << w_cfg[i]) - 1;
    if (cl) begin
      m_cnt[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
    end else if (m_pend[i]) begin
      if (ordy) m_pend[i] = 0;
    end else if (iv) begin
      t = m_sum[i] + op;
      if (t > maxv) begin
        m_ovf[i] = 1;
        t = SAT ? maxv : t - (maxv + 1);
      end
      m_sum[i] = t;
      m_cnt[i]++;
      if (m_cnt[i] == n_cfg[i]) begin
        m_pend[i] = 1; m_res[i] = m_sum[i]; m_rovf[i] = m_ovf[i];
        m_cnt[i] = 0; m_sum[i] = 0; m_ovf[i] = 0;
      end
    end
  endtask

  // Drive one cycle on the falling edge, check all instances, then advance the models
  task automatic cycle(input bit iv, input logic [7:0] sv, input bit cv,
                       input bit cl, input bit ordy);
    @(negedge clk);
    in_valid = iv; s = sv; cout = cv; clear = cl; out_ready = ordy;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("in_ready[%0d]", i), {31'b0, in_ready_w[i]}, {31'b0, !m_pend[i] && !cl});
      check($sformatf("out_valid[%0d]", i), {31'b0, out_valid_w[i]}, {31'b0, m_pend[i]});
      if (m_pend[i]) begin
        check($sformatf("acc_out[%0d]", i), acc_obs(i), m_res[i][31:0]);
        check($sformatf("overflow[%0d]", i), {31'b0, overflow_w[i]}, {31'b0, m_rovf[i]});
      end
      model_step(i, iv, longint'({cv, sv}), cl, ordy);
    end
    cyc++;
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once
  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; clear = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), {31'b0, out_valid_w[i]}, 32'd0);
      check($sformatf("rst_acc_out[%0d]", i), acc_obs(i), 32'd0);
      check($sformatf("rst_overflow[%0d]", i), {31'b0, overflow_w[i]}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int         vals[3] = '{5, 6, 7};
  int         idx;
  int         got;
  int         last_acc;
  bit         will_acc;
  logic [7:0] v;
  logic [8:0] exp_t4;

  initial begin
    rst_n = 1'b0; in_valid = 0; s = '0; cout = 0; clear = 0; out_ready = 0;
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("init_out_valid[%0d]", i), {31'b0, out_valid_w[i]}, 32'd0);
      check($sformatf("init_acc_out[%0d]", i), acc_obs(i), 32'd0);
      check($sformatf("init_overflow[%0d]", i), {31'b0, overflow_w[i]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // T1: reset in the middle of an accumulation
    for (int k = 0; k < 3; k++) cycle(1, 8'h37, 1, 0, 0);
    do_reset();
    cycle(0, 8'h00, 0, 0, 0);

    // T2: eight back-to-back beats of 511
    for (int k = 0; k < 8; k++) cycle(1, 8'hFF, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    check("t2_acc", {16'b0, acc0}, 32'h0FF8);
    check("t2_ovf", {31'b0, overflow_w[0]}, 32'd0);
    cycle(0, 8'h00, 0, 0, 1);

    // T3: gaps on input, then 5 cycles of backpressure with beats offered
    cycle(0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      cycle(1, 8'h01, 0, 0, 0);
      if (k % 2 == 1) cycle(0, 8'h00, 0, 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1, 8'h33, 0, 0, 0);
      check("t3_acc_hold", {16'b0, acc0}, 32'h0008);
      check("t3_in_ready", {31'b0, in_ready_w[0]}, 32'd0);
    end
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);

    // T4: overflow on the 9-bit, 2-beat instance (300 + 300)
    cycle(0, 8'h00, 0, 1, 0);
    cycle(1, 8'd44, 1, 0, 0);
    cycle(1, 8'd44, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    exp_t4 = SAT ? 9'd511 : 9'd88;
    check("t4_acc", {23'b0, acc1}, {23'b0, exp_t4});
    check("t4_ovf", {31'b0, overflow_w[1]}, 32'd1);
    cycle(0, 8'h00, 0, 0, 1);

    // T5: clear after three beats, with a beat offered in the clear cycle
    cycle(0, 8'h00, 0, 1, 0);
    for (int k = 0; k < 3; k++) cycle(1, 8'h40, 0, 0, 0);
    cycle(1, 8'h55, 0, 1, 0);
    for (int k = 0; k < 8; k++) cycle(1, 8'h02, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    check("t5_acc", {16'b0, acc0}, 32'h0010);
    cycle(0, 8'h00, 0, 0, 1);

    // T6: N_SAMPLES=1 with beats held until accepted and out_ready high
    cycle(0, 8'h00, 0, 1, 0);
    idx = 0; got = 0; last_acc = -1;
    for (int t = 0; t < 20 && got < 3; t++) begin
      will_acc = !m_pend[2];
      v = (idx < 3) ? 8'(vals[idx]) : 8'h00;
      cycle(idx < 3, v, 0, 0, 1);
      if (out_valid_w[2]) begin
        check("t6_result", {16'b0, acc2}, 32'(vals[got]));
        got++;
      end
      if (will_acc && idx < 3) begin
        if (last_acc >= 0) check("t6_gap", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        idx++;
      end
    end
    check("t6_count", 32'(got), 32'd3);

    // Randomised traffic with occasional clear and one mid-run reset
    cycle(0, 8'h00, 0, 1, 0);
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) do_reset();
      cycle($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom),
            $urandom_range(0, 99) < 2, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
